div_seq: RTL

- Multi-cycle 32-bit divide sequencer serving the EX stage for DIV and DIVU.
- EX supplies the operands and a start level; the block runs a radix-2 restoring division over 32 iterations.
- While the divide is in progress it holds the pipeline via stallreq_o.
- It returns {remainder, quotient} for the HI/LO write path.
- One instance sits beside ex. The pipeline control unit consumes stallreq_o and drives annul_i on flush or exception.

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_step.sv | 19 +
 rtl/div_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants for the divide sequencer: FSM encodings, handshake
// levels and the iteration count.
package div_seq_pkg;

  localparam int DivIterations = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial subtract of the divisor from the
// upper working bits, then shift in the quotient bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] work_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [2*DATA_W:0] work_o
);

  logic [DATA_W:0] diff;

  assign diff = work_i[2*DATA_W:DATA_W] - {1'b0, divisor_i};

  // diff[DATA_W] set means the partial remainder was smaller than the divisor.
  assign work_o = diff[DATA_W] ? {work_i[2*DATA_W-1:0], 1'b0}
                               : {diff[DATA_W-1:0], work_i[DATA_W-1:0], 1'b1};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside EX. Handshake: start_i is a level held
// until ready_o is seen; the result is valid while ready_o=1 and is dropped one
// cycle after start_i falls. stallreq_o = start_i & ~ready_o.
import div_seq_pkg::*;

module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o,
  output div_state_e          dbg_state_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d, step_w;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   abs1, abs2, quot, rem;
  logic                accept, last_iter;

  assign accept    = start_i & ~annul_i;
  assign last_iter = (cnt_q == CNT_W'(DATA_W));

  assign abs1 = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Remainder takes the dividend's sign; quotient takes the XOR of both signs.
  assign quot = q_neg_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
  assign rem  = r_neg_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];

  div_step #(.DATA_W(DATA_W)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (accept) state_d = (opdata2_i == '0) ? DivByZero : DivOn;
      end
      DivByZero: state_d = DivEnd;
      DivOn: begin
        if (annul_i)        state_d = DivFree;
        else if (last_iter) state_d = DivEnd;
      end
      DivEnd: begin
        if (!start_i || annul_i) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DivFree: begin
        ready_d = DivResultNotReady;
        if (accept) begin
          divisor_d = abs2;
          q_neg_d   = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          r_neg_d   = signed_div_i & opdata1_i[DATA_W-1];
          work_d    = {{DATA_W{1'b0}}, abs1, 1'b0};
          cnt_d     = '0;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          ready_d = DivResultNotReady;
        end else if (last_iter) begin
          result_d = {rem, quot};
          ready_d  = DivResultReady;
        end else begin
          work_d = step_w;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (!start_i || annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: ready_d = DivResultNotReady;
    endcase
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign stallreq_o  = start_i & ~ready_q;
  assign dbg_state_o = state_q;

endmodule
